// File: rtl/cmem_fill.sv
//==============================================================================
// Module      : cmem_fill
// Description : Line-fill responder. Gathers a cache line beat by beat from a
//               64-bit memory port and emits invalidates for external writes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cmem_fill #(
    parameter int LINE_W  = 512,
    parameter int BLK_LEN = 58
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLK_LEN-1:0] b_addr_c,
    input  logic               b_rd_c,
    output logic [LINE_W-1:0]  b_rdata_c,
    output logic               b_dv_c,
    output logic [BLK_LEN-1:0] b_inv_addr_c,
    output logic               inv,
    output logic [63:0]        m_addr,
    output logic               m_rd,
    input  logic               m_ready,
    input  logic [63:0]        m_rdata,
    input  logic               m_rvalid,
    input  logic               s_wr,
    input  logic [63:0]        s_addr
);

    localparam int BEATS    = LINE_W / 64;
    localparam int c_BEAT_W = $clog2(BEATS);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    logic [BLK_LEN-1:0]    r_blk;
    logic [c_BEAT_W-1:0]   r_beat;
    logic                  r_restart;
    logic [LINE_W-1:0]     r_line;
    logic                  r_inv;
    logic [BLK_LEN-1:0]    r_inv_addr;

    logic [BLK_LEN-1:0]    w_wr_blk;
    logic                  w_hit;
    logic                  w_unused;

    assign w_wr_blk = s_addr[63:64-BLK_LEN];
    assign w_unused = ^s_addr[63-BLK_LEN:0];

    // A write to the block being gathered poisons every beat fetched so far.
    assign w_hit = s_wr && (w_wr_blk == r_blk) &&
                   ((r_state == S_REQ) || (r_state == S_WAIT));

    assign m_rd         = (r_state == S_REQ);
    assign m_addr       = {r_blk, r_beat, 3'b000};
    assign b_dv_c       = (r_state == S_RESP);
    assign b_rdata_c    = b_dv_c ? r_line : '0;
    assign inv          = r_inv;
    assign b_inv_addr_c = r_inv_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_blk     <= '0;
            r_beat    <= '0;
            r_restart <= 1'b0;
            r_line    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (b_rd_c) begin
                        r_blk     <= b_addr_c;
                        r_beat    <= '0;
                        r_restart <= 1'b0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_hit) begin
                        r_restart <= 1'b1;
                    end
                    if (m_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (m_rvalid) begin
                        r_line[{r_beat, 6'd0} +: 64] <= m_rdata;
                        if (r_restart || w_hit) begin
                            r_beat    <= '0;
                            r_restart <= 1'b0;
                            r_state   <= S_REQ;
                        end else if (r_beat == c_LAST_BEAT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_state <= S_REQ;
                        end
                    end else if (w_hit) begin
                        r_restart <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Invalidate path runs regardless of the fill state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv      <= 1'b0;
            r_inv_addr <= '0;
        end else begin
            r_inv <= s_wr;
            if (s_wr) begin
                r_inv_addr <= w_wr_blk;
            end
        end
    end

endmodule

`default_nettype wire
